// File: rtl/rv32_data_bus_ctrl.sv
// Load/store bus master: issues valid/ready data-bus requests for the execute-stage
// memory op and returns aligned, extended load data or fault causes one cycle later.
module rv32_data_bus_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_read_in,
    input  logic        op_write_in,
    input  logic [1:0]  op_width_in,
    input  logic        op_unsigned_in,
    input  logic [31:0] op_address_in,
    input  logic [31:0] op_write_value_in,
    input  logic        kill_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        mem_load_valid_out,
    output logic [31:0] mem_read_value_out,
    output logic        mem_trap_out,
    output logic [3:0]  mem_trap_cause_out
);

    localparam int unsigned CNT_W = (TIMEOUT < 4) ? 2 : $clog2(TIMEOUT + 1);

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [29:0]      lat_addr;
    logic             lat_read;
    logic             lat_write;
    logic [3:0]       lat_mask;
    logic [31:0]      lat_value;
    logic [1:0]       lat_width;
    logic             lat_unsigned;
    logic [1:0]       lat_off;
    logic [CNT_W-1:0] cnt;

    logic        op_any;
    logic        misaligned;
    logic        issue;
    logic        expired;
    logic [3:0]  in_mask;
    logic [31:0] in_value;
    logic [1:0]  cur_width;
    logic        cur_unsigned;
    logic [1:0]  cur_off;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        done_load;
    logic        trap_next;
    logic [3:0]  cause_next;

    // Request decode from the execute-stage op
    always_comb begin
        op_any     = op_read_in | op_write_in;
        misaligned = ((op_width_in == 2'd1) && op_address_in[0]) ||
                     (op_width_in[1] && (op_address_in[1:0] != 2'b00));
        issue      = reset_n && (state == IDLE) && op_any && !misaligned && !kill_in;
        expired    = (TIMEOUT != 0) && ((32'(cnt) + 32'd2) >= TIMEOUT);
        case (op_width_in)
            2'd0:    in_mask = 4'(4'b0001 << op_address_in[1:0]);
            2'd1:    in_mask = 4'(4'b0011 << op_address_in[1:0]);
            default: in_mask = 4'b1111;
        endcase
        case (op_width_in)
            2'd0:    in_value = {4{op_write_value_in[7:0]}};
            2'd1:    in_value = {2{op_write_value_in[15:0]}};
            default: in_value = op_write_value_in;
        endcase
    end

    // Load alignment uses live inputs on a zero-wait hit, latched values otherwise
    always_comb begin
        cur_width    = (state == IDLE) ? op_width_in       : lat_width;
        cur_unsigned = (state == IDLE) ? op_unsigned_in    : lat_unsigned;
        cur_off      = (state == IDLE) ? op_address_in[1:0] : lat_off;
        shifted      = data_read_value_in >> {cur_off, 3'b000};
        case (cur_width)
            2'd0:    load_ext = cur_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = cur_unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and completion/trap events
    always_comb begin
        state_next = state;
        done_load  = 1'b0;
        trap_next  = 1'b0;
        cause_next = 4'd0;
        case (state)
            IDLE: begin
                if (reset_n && op_any && !kill_in) begin
                    if (misaligned) begin
                        trap_next  = 1'b1;
                        cause_next = op_write_in ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                    end else if (data_ready_in) begin
                        done_load = op_read_in;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_ready_in) begin
                    state_next = IDLE;
                    done_load  = lat_read && !kill_in;
                end else if (expired) begin
                    state_next = IDLE;
                    trap_next  = !kill_in;
                    cause_next = kill_in ? 4'd0 :
                                 (lat_write ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT);
                end else if (kill_in) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (data_ready_in || expired) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs: live in IDLE, held from latches while waiting
    always_comb begin
        data_address_out     = 32'd0;
        data_read_out        = 1'b0;
        data_write_out       = 1'b0;
        data_write_mask_out  = 4'd0;
        data_write_value_out = 32'd0;
        if (state == IDLE) begin
            if (issue) begin
                data_address_out = {op_address_in[31:2], 2'b00};
                data_read_out    = op_read_in;
                data_write_out   = op_write_in;
                if (op_write_in) begin
                    data_write_mask_out  = in_mask;
                    data_write_value_out = in_value;
                end
            end
        end else begin
            data_address_out     = {lat_addr, 2'b00};
            data_read_out        = lat_read;
            data_write_out       = lat_write;
            data_write_mask_out  = lat_mask;
            data_write_value_out = lat_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_addr           <= '0;
            lat_read           <= 1'b0;
            lat_write          <= 1'b0;
            lat_mask           <= '0;
            lat_value          <= '0;
            lat_width          <= '0;
            lat_unsigned       <= 1'b0;
            lat_off            <= '0;
            cnt                <= '0;
            mem_load_valid_out <= 1'b0;
            mem_read_value_out <= '0;
            mem_trap_out       <= 1'b0;
            mem_trap_cause_out <= '0;
        end else begin
            if (issue) begin
                lat_addr     <= op_address_in[31:2];
                lat_read     <= op_read_in;
                lat_write    <= op_write_in;
                lat_mask     <= op_write_in ? in_mask : 4'd0;
                lat_value    <= op_write_in ? in_value : 32'd0;
                lat_width    <= op_width_in;
                lat_unsigned <= op_unsigned_in;
                lat_off      <= op_address_in[1:0];
                cnt          <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
            mem_load_valid_out <= done_load;
            mem_read_value_out <= done_load ? load_ext : 32'd0;
            mem_trap_out       <= trap_next;
            mem_trap_cause_out <= cause_next;
        end
    end

endmodule

// File: tb/tb_rv32_data_bus_ctrl.sv
// Directed bench for rv32_data_bus_ctrl: one long-timeout instance and one with TIMEOUT=4.
module tb_rv32_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_read, op_write, op_unsigned, kill, ready;
    logic [1:0]  op_width;
    logic [31:0] op_addr, op_wval, rdata;

    logic [31:0] bus_addr, bus_wval, load_val;
    logic        bus_rd, bus_wr, load_valid, trap;
    logic [3:0]  bus_mask, cause;

    logic [31:0] t_addr, t_wval, t_load_val;
    logic        t_rd, t_wr, t_load_valid, t_trap;
    logic [3:0]  t_mask, t_cause;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32_data_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_read_in(op_read), .op_write_in(op_write), .op_width_in(op_width),
        .op_unsigned_in(op_unsigned), .op_address_in(op_addr), .op_write_value_in(op_wval),
        .kill_in(kill),
        .data_address_out(bus_addr), .data_read_out(bus_rd), .data_write_out(bus_wr),
        .data_write_mask_out(bus_mask), .data_write_value_out(bus_wval),
        .data_read_value_in(rdata), .data_ready_in(ready),
        .mem_load_valid_out(load_valid), .mem_read_value_out(load_val),
        .mem_trap_out(trap), .mem_trap_cause_out(cause)
    );

    rv32_data_bus_ctrl #(.TIMEOUT(4)) dut_t (
        .clk(clk), .reset_n(reset_n),
        .op_read_in(op_read), .op_write_in(op_write), .op_width_in(op_width),
        .op_unsigned_in(op_unsigned), .op_address_in(op_addr), .op_write_value_in(op_wval),
        .kill_in(kill),
        .data_address_out(t_addr), .data_read_out(t_rd), .data_write_out(t_wr),
        .data_write_mask_out(t_mask), .data_write_value_out(t_wval),
        .data_read_value_in(rdata), .data_ready_in(ready),
        .mem_load_valid_out(t_load_valid), .mem_read_value_out(t_load_val),
        .mem_trap_out(t_trap), .mem_trap_cause_out(t_cause)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] v, input logic k,
                         input logic rdy, input logic [31:0] rv);
        op_read = rd; op_write = wr; op_width = w; op_unsigned = u;
        op_addr = a; op_wval = v; kill = k; ready = rdy; rdata = rv;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        tests++; if ({bus_rd, bus_wr, bus_mask, bus_addr, bus_wval} !== 70'd0) begin fails++; $display("FAIL reset_bus: got rd=%0b wr=%0b addr=%h want all 0", bus_rd, bus_wr, bus_addr); end
        tests++; if ({load_valid, load_val, trap, cause} !== 38'd0) begin fails++; $display("FAIL reset_mem: got valid=%0b val=%h trap=%0b cause=%0d want all 0", load_valid, load_val, trap, cause); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_lw_zero_wait();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tests++; if (bus_rd !== 1'b1) begin fails++; $display("FAIL lw_req: got %0b want 1", bus_rd); end
        tests++; if (bus_addr !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h want 00000100", bus_addr); end
        tests++; if (bus_mask !== 4'b0000) begin fails++; $display("FAIL lw_mask: got %b want 0000", bus_mask); end
        step();
        idle_inputs();
        tests++; if (bus_rd !== 1'b0) begin fails++; $display("FAIL lw_req_drop: got %0b want 0", bus_rd); end
        tests++; if (load_valid !== 1'b1 || load_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_result: got valid=%0b val=%h want 1 deadbeef", load_valid, load_val); end
        step();
        tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL lw_pulse: got %0b want 0", load_valid); end
    endtask

    task automatic test_lb_wait();
        logic [31:0] exp_val [2];
        exp_val[0] = 32'hFFFF_FF80;
        exp_val[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            drive(1'b1, 1'b0, 2'd0, u[0], 32'h0000_0103, 32'd0, 1'b0, 1'b0, 32'd0);
            tests++; if (bus_rd !== 1'b1 || bus_addr !== 32'h100) begin fails++; $display("FAIL lb_req0 u=%0d: got rd=%0b addr=%h want 1 00000100", u, bus_rd, bus_addr); end
            step();
            idle_inputs();
            tests++; if (bus_rd !== 1'b1 || bus_addr !== 32'h100) begin fails++; $display("FAIL lb_req1 u=%0d: got rd=%0b addr=%h want 1 00000100", u, bus_rd, bus_addr); end
            step();
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h80FF_0000);
            tests++; if (bus_rd !== 1'b1 || load_valid !== 1'b0) begin fails++; $display("FAIL lb_req2 u=%0d: got rd=%0b valid=%0b want 1 0", u, bus_rd, load_valid); end
            step();
            idle_inputs();
            tests++; if (bus_rd !== 1'b0) begin fails++; $display("FAIL lb_drop u=%0d: got %0b want 0", u, bus_rd); end
            tests++; if (load_valid !== 1'b1 || load_val !== exp_val[u]) begin fails++; $display("FAIL lb_result u=%0d: got valid=%0b val=%h want 1 %h", u, load_valid, load_val, exp_val[u]); end
            step();
        end
    endtask

    task automatic test_store();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 1'b0, 1'b1, 32'd0);
        tests++; if (bus_wr !== 1'b1 || bus_rd !== 1'b0) begin fails++; $display("FAIL sh_req: got wr=%0b rd=%0b want 1 0", bus_wr, bus_rd); end
        tests++; if (bus_mask !== 4'b1100) begin fails++; $display("FAIL sh_mask: got %b want 1100", bus_mask); end
        tests++; if (bus_wval !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_data: got %h want abcdabcd", bus_wval); end
        step();
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 1'b0, 1'b1, 32'd0);
        tests++; if (load_valid !== 1'b0 || trap !== 1'b0) begin fails++; $display("FAIL sh_noresult: got valid=%0b trap=%0b want 0 0", load_valid, trap); end
        tests++; if (bus_mask !== 4'b1000 || bus_wval !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_lane: got mask=%b data=%h want 1000 a5a5a5a5", bus_mask, bus_wval); end
        step();
        drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0204, 32'h0BAD_F00D, 1'b0, 1'b1, 32'd0);
        tests++; if (bus_mask !== 4'b1111 || bus_wval !== 32'h0BAD_F00D || bus_addr !== 32'h204) begin fails++; $display("FAIL sw_w3: got mask=%b data=%h addr=%h want 1111 0badf00d 00000204", bus_mask, bus_wval, bus_addr); end
        step();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h1234_ABCD, 1'b0, 1'b1, 32'd0);
        tests++; if (bus_wr !== 1'b0 || bus_rd !== 1'b0) begin fails++; $display("FAIL sh_mis_noreq: got wr=%0b rd=%0b want 0 0", bus_wr, bus_rd); end
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 1'b0, 1'b1, 32'd0);
        tests++; if (trap !== 1'b1 || cause !== 4'd6) begin fails++; $display("FAIL sh_mis_trap: got trap=%0b cause=%0d want 1 6", trap, cause); end
        tests++; if (bus_rd !== 1'b0) begin fails++; $display("FAIL lw_mis_noreq: got %0b want 0", bus_rd); end
        step();
        idle_inputs();
        tests++; if (trap !== 1'b1 || cause !== 4'd4) begin fails++; $display("FAIL lw_mis_trap: got trap=%0b cause=%0d want 1 4", trap, cause); end
        step();
        tests++; if (trap !== 1'b0) begin fails++; $display("FAIL mis_pulse: got %0b want 0", trap); end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_cause [2];
        exp_cause[0] = 4'd5;
        exp_cause[1] = 4'd7;
        for (int s = 0; s < 2; s++) begin
            drive(s == 0, s == 1, 2'd2, 1'b0, 32'h0000_0200, 32'h5555_AAAA, 1'b0, 1'b0, 32'd0);
            for (int i = 0; i < 4; i++) begin
                tests++; if ((t_rd | t_wr) !== 1'b1 || t_trap !== 1'b0) begin fails++; $display("FAIL to_req s=%0d cyc=%0d: got req=%0b trap=%0b want 1 0", s, i, t_rd | t_wr, t_trap); end
                step();
                idle_inputs();
            end
            tests++; if ((t_rd | t_wr) !== 1'b0) begin fails++; $display("FAIL to_drop s=%0d: got %0b want 0", s, t_rd | t_wr); end
            tests++; if (t_trap !== 1'b1 || t_cause !== exp_cause[s]) begin fails++; $display("FAIL to_trap s=%0d: got trap=%0b cause=%0d want 1 %0d", s, t_trap, t_cause, exp_cause[s]); end
            step();
            tests++; if (t_trap !== 1'b0 || t_load_valid !== 1'b0) begin fails++; $display("FAIL to_pulse s=%0d: got trap=%0b valid=%0b want 0 0", s, t_trap, t_load_valid); end
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_kill_drain();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        tests++; if (bus_rd !== 1'b1) begin fails++; $display("FAIL kill_req: got %0b want 1", bus_rd); end
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, i == 2, 32'h1111_2222);
            tests++; if (bus_rd !== 1'b1 || load_valid !== 1'b0 || trap !== 1'b0) begin fails++; $display("FAIL drain_hold cyc=%0d: got rd=%0b valid=%0b trap=%0b want 1 0 0", i, bus_rd, load_valid, trap); end
        end
        step();
        idle_inputs();
        tests++; if (bus_rd !== 1'b0 || load_valid !== 1'b0 || trap !== 1'b0) begin fails++; $display("FAIL drain_end: got rd=%0b valid=%0b trap=%0b want 0 0 0", bus_rd, load_valid, trap); end
        step();
        tests++; if (load_valid !== 1'b0 || trap !== 1'b0) begin fails++; $display("FAIL drain_quiet: got valid=%0b trap=%0b want 0 0", load_valid, trap); end
        // kill coinciding with ready while waiting
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h3333_4444);
        step();
        idle_inputs();
        tests++; if (bus_rd !== 1'b0 || load_valid !== 1'b0 || trap !== 1'b0) begin fails++; $display("FAIL kill_ready: got rd=%0b valid=%0b trap=%0b want 0 0 0", bus_rd, load_valid, trap); end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0301, 32'd0, 1'b1, 1'b1, 32'd0);
        tests++; if (bus_rd !== 1'b0) begin fails++; $display("FAIL kill_idle_req: got %0b want 0", bus_rd); end
        step();
        drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0302, 32'd0, 1'b0, 1'b1, 32'h8001_0000);
        tests++; if (trap !== 1'b0 || load_valid !== 1'b0) begin fails++; $display("FAIL kill_idle_quiet: got trap=%0b valid=%0b want 0 0", trap, load_valid); end
        tests++; if (bus_rd !== 1'b1) begin fails++; $display("FAIL after_kill_req: got %0b want 1", bus_rd); end
        step();
        idle_inputs();
        tests++; if (load_valid !== 1'b1 || load_val !== 32'h0000_8001) begin fails++; $display("FAIL lhu_result: got valid=%0b val=%h want 1 00008001", load_valid, load_val); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        tests++; if (bus_rd !== 1'b1) begin fails++; $display("FAIL rmid_wait: got %0b want 1", bus_rd); end
        reset_n = 1'b0;
        step();
        tests++; if ({bus_rd, bus_wr, bus_mask, bus_addr, bus_wval, load_valid, load_val, trap, cause} !== 108'd0) begin fails++; $display("FAIL rmid_zero: got rd=%0b addr=%h valid=%0b trap=%0b want all 0", bus_rd, bus_addr, load_valid, trap); end
        reset_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, 1'b0, 1'b1, 32'h1122_3344);
        tests++; if (bus_rd !== 1'b1 || bus_addr !== 32'h104) begin fails++; $display("FAIL rmid_req: got rd=%0b addr=%h want 1 00000104", bus_rd, bus_addr); end
        step();
        idle_inputs();
        tests++; if (load_valid !== 1'b1 || load_val !== 32'h1122_3344) begin fails++; $display("FAIL rmid_result: got valid=%0b val=%h want 1 11223344", load_valid, load_val); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_wait();
        test_store();
        test_timeout();
        test_kill_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
